// File: rtl/cbus_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cbus_ram_responder
//  Description : CBus slave that serves single and burst read/write
//                transactions from an internal 32-bit word RAM, with a
//                programmable latency before the first beat.
//  Revision    : 1.0  initial release
// ============================================================================

package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_ram_responder
    import cbus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t         r_state;
    logic [3:0]     r_wait_cnt;
    logic [3:0]     r_beat_cnt;
    logic [3:0]     r_len;
    logic           r_is_write;
    logic [AW-1:0]  r_base;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic [AW-1:0]  w_idx;
    logic           w_in_burst;
    logic           w_last;
    logic           w_wr_en;
    logic           w_unused_bits;

    // Beat index wraps naturally at the top of the RAM through AW-bit arithmetic.
    assign w_idx      = r_base + AW'(r_beat_cnt);
    assign w_in_burst = (r_state == S_BURST);
    assign w_last     = w_in_burst && (r_beat_cnt == r_len);
    // A beat with valid low is a protocol violation and must not write.
    assign w_wr_en    = w_in_burst && r_is_write && creq.valid && resetn;

    // Size only qualifies strobe and the byte offset is ignored.
    assign w_unused_bits = ^{creq.size, creq.addr[1:0], creq.addr[31:AW+2]};

    assign cresp.ready = w_in_burst;
    assign cresp.last  = w_last;
    assign cresp.data  = (w_in_burst && !r_is_write) ? r_mem[w_idx] : 32'h0;

    // Transaction sequencing: capture in IDLE, count latency, then stream beats.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_beat_cnt <= 4'd0;
            r_len      <= 4'd0;
            r_is_write <= 1'b0;
            r_base     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_beat_cnt <= 4'd0;
                    if (creq.valid) begin
                        r_base     <= creq.addr[AW+1:2];
                        r_len      <= creq.len;
                        r_is_write <= creq.is_write;
                        r_wait_cnt <= 4'(LATENCY);
                        r_state    <= (LATENCY == 0) ? S_BURST : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (!creq.valid) begin
                        r_state <= S_IDLE;
                    end else if (r_wait_cnt == 4'd1) begin
                        r_state <= S_BURST;
                    end
                end
                S_BURST: begin
                    r_beat_cnt <= r_beat_cnt + 4'd1;
                    if (!creq.valid || w_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Byte-lane write port; RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (creq.strobe[i]) begin
                    r_mem[w_idx][8*i +: 8] <= creq.data[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
